// File: rtl/miriscv_mult_seq_if.sv
// Request/response bundle between miriscv_mdu (master) and the iterative multiplier (slave).
interface miriscv_mult_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic                req_i;
    logic [XLEN:0]       ai_i;
    logic [XLEN:0]       bi_i;
    logic                zf_i;
    logic [2*XLEN-1:0]   r_o;
    logic                rdy_o;

    modport master (output req_i, ai_i, bi_i, zf_i, input r_o, rdy_o);
    modport slave  (input req_i, ai_i, bi_i, zf_i, output r_o, rdy_o);
endinterface

// File: rtl/miriscv_mult_seq.sv
// Iterative signed/unsigned multiplier, BITS_PER_CYCLE multiplier bits per cycle.
// Optional MIRISCV_MULT_EARLY_TERM_EN: leave BUSY as soon as the remaining multiplier bits are zero.
module miriscv_mult_seq #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    miriscv_mult_seq_if.slave   bus
);

    localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mag_b_q, mag_b_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [XLEN-1:0]     mag_b_shr;
    logic [2*XLEN-1:0]   pp;
    logic [2*XLEN-1:0]   acc_sum;
    logic                last;
    logic                rdy;
    logic [2*XLEN-1:0]   r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        mag_a = bus.ai_i[XLEN] ? (~bus.ai_i[XLEN-1:0] + XLEN'(1)) : bus.ai_i[XLEN-1:0];
        mag_b = bus.bi_i[XLEN] ? (~bus.bi_i[XLEN-1:0] + XLEN'(1)) : bus.bi_i[XLEN-1:0];

        // The multiplicand is kept pre-shifted, so the running shift amount needs no register.
        pp = '0;
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mag_b_q[j]) pp = pp + (mcand_q << j);
        end
        acc_sum   = acc_q + pp;
        mag_b_shr = mag_b_q >> BITS_PER_CYCLE;

`ifdef MIRISCV_MULT_EARLY_TERM_EN
        last = (cnt_q == CW'(1)) || (mag_b_shr == '0);
`else
        last = (cnt_q == CW'(1));
`endif

        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mag_b_d  = mag_b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        result_d = result_q;
        rdy      = 1'b0;
        r        = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    if (bus.zf_i) begin
                        rdy = 1'b1;
                    end else begin
                        mcand_d = (2*XLEN)'(mag_a);
                        mag_b_d = mag_b;
                        neg_d   = bus.ai_i[XLEN] ^ bus.bi_i[XLEN];
                        acc_d   = '0;
                        cnt_d   = CW'(N);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!bus.req_i) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d   = acc_sum;
                    mcand_d = mcand_q << BITS_PER_CYCLE;
                    mag_b_d = mag_b_shr;
                    cnt_d   = cnt_q - CW'(1);
                    if (last) begin
                        result_d = neg_q ? -acc_sum : acc_sum;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                rdy     = bus.req_i;
                r       = bus.req_i ? result_q : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdy_o = rdy;
    assign bus.r_o   = r;

endmodule

// File: tb/tb_miriscv_mult_seq.sv
// Scoreboard bench for miriscv_mult_seq: driver pushes expected product and response cycle, monitor checks.
module tb_miriscv_mult_seq;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BPC  = 2;

    typedef struct {
        logic [2*XLEN-1:0] r;
        int unsigned       cyc;
        string             name;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned n_cmp;
    int unsigned n_bad;
    exp_t        sb[$];

    miriscv_mult_seq_if #(.XLEN(XLEN)) bus ();

    miriscv_mult_seq #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycles from request to rdy_o for a non-zero operand pair.
    function automatic int unsigned lat_of(input logic [XLEN:0] b);
        logic [XLEN-1:0] m;
        int unsigned k;
        m = b[XLEN] ? (~b[XLEN-1:0] + 32'd1) : b[XLEN-1:0];
`ifdef MIRISCV_MULT_EARLY_TERM_EN
        k = 1;
        while (k < XLEN / BPC && (m >> (BPC * k)) != 0) k++;
        return k + 1;
`else
        m = '0;
        k = m;
        return XLEN / BPC + 1 + k;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rdy_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rdy: cycle %0d r_o=%h, no request outstanding", cyc, bus.r_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_cmp++;
                    if (bus.r_o !== e.r) begin
                        n_bad++;
                        $display("FAIL %s product: got %h want %h", e.name, bus.r_o, e.r);
                    end
                    n_cmp++;
                    if (cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL %s latency: rdy at cycle %0d want %0d", e.name, cyc, e.cyc);
                    end
                end
            end else if (bus.r_o !== '0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL r_zero_when_idle: cycle %0d r_o=%h want 0", cyc, bus.r_o);
            end
        end
    end

    task automatic wait_rdy(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rdy_o === 1'b1) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s timeout: rdy_o=0 after 40 cycles want 1", name);
    endtask

    task automatic issue(input string name, input logic [XLEN:0] a, input logic [XLEN:0] b,
                         input logic zf, input logic [2*XLEN-1:0] exp_r);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req_i = 1'b1;
        bus.ai_i  = a;
        bus.bi_i  = b;
        bus.zf_i  = zf;
        e.r    = exp_r;
        e.cyc  = zf ? cyc : cyc + lat_of(b);
        e.name = name;
        sb.push_back(e);
        wait_rdy(name);
    endtask

    task automatic idle(input int unsigned n);
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        bus.zf_i  = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string name, input logic [2*XLEN-1:0] got, input logic [2*XLEN-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc       = 0;
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        bus.req_i = 1'b0;
        bus.ai_i  = '0;
        bus.bi_i  = '0;
        bus.zf_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdy", 64'(bus.rdy_o), 64'd0);
        check("reset_r",   bus.r_o,        64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        issue("mul_7_m3",      33'h0_00000007, 33'h1_FFFFFFFD, 1'b0, 64'hFFFFFFFF_FFFFFFEB);
        idle(2);
        issue("mulhu_max",     33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        issue("mulh_min_min",  33'h1_80000000, 33'h1_80000000, 1'b0, 64'h40000000_00000000);
        idle(2);
        issue("zero_path",     33'h0_00000000, 33'h0_12345678, 1'b1, 64'h0);
        issue("b2b_3x5",       33'h0_00000003, 33'h0_00000005, 1'b0, 64'd15);
        issue("zero_b",        33'h0_00000005, 33'h0_00000000, 1'b1, 64'h0);
        issue("neg_neg",       33'h1_FFFFFFF6, 33'h1_FFFFFFF9, 1'b0, 64'h46);
        issue("pos_min",       33'h0_12345678, 33'h1_80000000, 1'b0, 64'hF6E5D4C4_00000000);
        idle(2);

        // Abort: req dropped in cycle 5 of a BUSY op; monitor flags any stray rdy_o.
        @(posedge clk);
        #1;
        bus.req_i = 1'b1;
        bus.ai_i  = 33'h0_00001000;
        bus.bi_i  = 33'h0_00000010;
        bus.zf_i  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        repeat (25) @(posedge clk);
        issue("after_abort",   33'h1_FFFFFFFF, 33'h0_00000002, 1'b0, 64'hFFFFFFFF_FFFFFFFE);
        idle(2);

        // Reset in cycle 8 of a BUSY op.
        @(posedge clk);
        #1;
        bus.req_i = 1'b1;
        bus.ai_i  = 33'h0_0000FFFF;
        bus.bi_i  = 33'h0_0000FFFF;
        repeat (8) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.req_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midop_reset_rdy", 64'(bus.rdy_o), 64'd0);
        check("midop_reset_r",   bus.r_o,        64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        issue("after_reset",   33'h0_00000064, 33'h0_00000003, 1'b0, 64'h12C);
        issue("msb_multiplier", 33'h0_00000064, 33'h0_80000000, 1'b0, 64'h00000032_00000000);
        idle(25);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d responses outstanding want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
